// File: rtl/gpa_fhdo_sched.sv
// gpa_fhdo_sched: launches waveform or host word sets to the SPI serialiser.
// A one-entry pending buffer holds the newest waveform set; the FSM waits for
// the serialiser to go busy, then idle, then a hold-off gap before the next launch.
module gpa_fhdo_sched #(
  parameter int BUSY_TIMEOUT = 8,
  parameter int HOLDOFF      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wave_valid_i,
  input  logic [23:0] wave_x_i,
  input  logic [23:0] wave_y_i,
  input  logic [23:0] wave_z_i,
  input  logic [23:0] wave_z2_i,
  input  logic        host_valid_i,
  input  logic [23:0] host_x_i,
  input  logic [23:0] host_y_i,
  input  logic [23:0] host_z_i,
  input  logic [23:0] host_z2_i,
  output logic        host_ready_o,
  output logic        iface_valid_o,
  output logic [23:0] iface_x_o,
  output logic [23:0] iface_y_o,
  output logic [23:0] iface_z_o,
  output logic [23:0] iface_z2_o,
  input  logic        iface_busy_i,
  input  logic        stat_clr_i,
  output logic [15:0] overrun_cnt_o,
  output logic        timeout_err_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  // Last count value of each timed state; a zero hold-off still spends one cycle in GAP.
  localparam logic [15:0] TO_LAST = 16'(BUSY_TIMEOUT - 1);
  localparam logic [15:0] HO_LAST = 16'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [3:0][23:0] buf_q, buf_d;
  logic [3:0][23:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic [15:0]      ovr_q, ovr_d;
  logic             terr_q, terr_d;

  logic [3:0][23:0] wave_w, host_w;
  logic             idle_free, launch_pend, launch_wave, launch_host;

  // Word index 0 = x, 1 = y, 2 = z, 3 = z2.
  assign wave_w = {wave_z2_i, wave_z_i, wave_y_i, wave_x_i};
  assign host_w = {host_z2_i, host_z_i, host_y_i, host_x_i};

  // Launch priority: buffered waveform, then a fresh waveform strobe, then host.
  assign idle_free   = (state_q == IDLE) && !iface_busy_i;
  assign launch_pend = idle_free && pend_q;
  assign launch_wave = idle_free && !pend_q && wave_valid_i;
  assign launch_host = idle_free && !pend_q && !wave_valid_i && host_valid_i;
  // Gated by rst_n so the handshake stays low while the block is held in reset.
  assign host_ready_o = rst_n && idle_free && !pend_q && !wave_valid_i;

  // Next-state logic: launch selection, pending buffer, sequencing and status.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    buf_d   = buf_q;
    out_d   = out_q;
    ovr_d   = ovr_q;
    terr_d  = terr_q;
    valid_d = launch_pend || launch_wave || launch_host;

    if (launch_pend) begin
      out_d  = buf_q;
      pend_d = 1'b0;
    end else if (launch_wave) begin
      out_d = wave_w;
    end else if (launch_host) begin
      out_d = host_w;
    end

    // A strobe not launched directly lands in the buffer; it only counts as an
    // overrun if it displaces a set that is not leaving this cycle.
    if (wave_valid_i && !launch_wave) begin
      buf_d  = wave_w;
      pend_d = 1'b1;
      if (pend_q && !launch_pend && (ovr_q != 16'hFFFF)) begin
        ovr_d = ovr_q + 16'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (valid_d) begin
          state_d = WAIT_BUSY;
          cnt_d   = '0;
        end
      end
      WAIT_BUSY: begin
        if (iface_busy_i) begin
          state_d = WAIT_DONE;
        end else if (cnt_q >= TO_LAST) begin
          terr_d  = 1'b1;
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT_DONE: begin
        if (!iface_busy_i) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt_q >= HO_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (stat_clr_i) begin
      ovr_d  = '0;
      terr_d = 1'b0;
    end
  end

  // State and output registers; reset drops any pending set and in-flight transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      buf_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      terr_q  <= terr_d;
    end
  end

  assign iface_valid_o = valid_q;
  assign iface_x_o     = out_q[0];
  assign iface_y_o     = out_q[1];
  assign iface_z_o     = out_q[2];
  assign iface_z2_o    = out_q[3];
  assign overrun_cnt_o = ovr_q;
  assign timeout_err_o = terr_q;
  assign busy_o        = (state_q != IDLE) || pend_q;

endmodule

// File: doc/gpa_fhdo_sched.md
GPA_FHDO_SCHED -- requirements
Module: gpa_fhdo_sched

Interface
REQ-001 Parameter BUSY_TIMEOUT, 8: max cycles after a launch to wait for iface_busy_i high.
REQ-002 Parameter HOLDOFF, 4: idle gap in cycles between end of one transfer and the next launch; 0 allowed.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 wave_valid_i  in  1  1-cycle strobe, new waveform sample set.
REQ-006 wave_x_i, wave_y_i, wave_z_i, wave_z2_i  in  24 each  waveform words.
REQ-007 host_valid_i  in  1  host (static/calibration) word set request.
REQ-008 host_x_i, host_y_i, host_z_i, host_z2_i  in  24 each  host words.
REQ-009 host_ready_o  out  1  host handshake ready.
REQ-010 iface_valid_o  out  1  1-cycle launch strobe to SPI serialiser.
REQ-011 iface_x_o, iface_y_o, iface_z_o, iface_z2_o  out  24 each  words to serialiser.
REQ-012 iface_busy_i  in  1  serialiser busy.
REQ-013 stat_clr_i  in  1  clears status.
REQ-014 overrun_cnt_o  out  16  dropped waveform sets.
REQ-015 timeout_err_o  out  1  sticky, serialiser never went busy.
REQ-016 busy_o  out  1  high whenever state is not IDLE or a waveform set is pending.

Function
REQ-017 One-entry waveform pending buffer; wave_valid_i high loads all four words and sets pending.
REQ-018 wave_valid_i while pending set and not being launched that cycle: overwrite buffer, increment overrun_cnt_o, saturating at 0xFFFF.
REQ-019 wave_valid_i in the same cycle the pending set launches: old set launches, new set becomes pending, no overrun.
REQ-020 FSM states IDLE, WAIT_BUSY, WAIT_DONE, GAP.
REQ-021 IDLE, iface_busy_i low, pending set: register waveform words to iface_*_o, pulse iface_valid_o one cycle, clear pending, go WAIT_BUSY.
REQ-022 IDLE, iface_busy_i low, pending clear, host_valid_i high: accept host set (host_ready_o high that cycle), launch as REQ-021, go WAIT_BUSY.
REQ-023 host_ready_o high only in IDLE with pending clear and iface_busy_i low; waveform always wins over host.
REQ-024 IDLE with iface_busy_i high: no launch.
REQ-025 Latency: wave_valid_i high in cycle k with FSM idle and serialiser free -> iface_valid_o high in cycle k+1.
REQ-026 iface_*_o hold their values from launch until the next launch.
REQ-027 WAIT_BUSY: iface_busy_i high -> WAIT_DONE; else after BUSY_TIMEOUT cycles set timeout_err_o, go GAP.
REQ-028 WAIT_DONE: iface_busy_i low -> GAP.
REQ-029 GAP: count HOLDOFF cycles then IDLE; HOLDOFF=0 -> IDLE on next edge.
REQ-030 Pending buffer keeps accepting waveform sets in every state.
REQ-031 stat_clr_i clears overrun_cnt_o and timeout_err_o; clear wins over a same-cycle increment or set.

Reset
REQ-032 rst_n low: state IDLE, pending clear, iface_valid_o 0, iface_*_o 0, host_ready_o 0, overrun_cnt_o 0, timeout_err_o 0, busy_o 0.
REQ-033 Reset mid-transfer drops the pending set and in-flight tracking; after release no launch until iface_busy_i is low.

Verification
REQ-034 wave set x=0x000123 in cycle k, serialiser busy 2..60 cycles after launch -> one iface_valid_o in k+1, iface_x_o=0x000123 held; next launch no earlier than HOLDOFF cycles after busy falls.
REQ-035 Three wave strobes during one transfer -> overrun_cnt_o=2, only the third set is launched after GAP.
REQ-036 host_valid_i and wave_valid_i high together in IDLE -> waveform launched, host_ready_o low; host accepted at the next IDLE with pending clear.
REQ-037 iface_busy_i held low after launch -> timeout_err_o=1 after 8 cycles, FSM returns to IDLE; stat_clr_i -> 0.
REQ-038 rst_n low during WAIT_DONE with iface_busy_i high and pending set -> all outputs 0; after release no iface_valid_o until iface_busy_i falls.
REQ-039 overrun count preloaded to 0xFFFF by repeated overruns, one more overrun -> stays 0xFFFF; stat_clr_i with a same-cycle overrun -> 0.
